// File: rtl/fib_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fib_pkg                                                    |
// | Brief   : Shared widths, requester ids, arbiter states and hash tag  |
// |           type for the FIB hash-unit sharing logic.                  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fib_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int HASH_W   = 10;

  // Owner of a hash request
  typedef enum logic [0:0] {
    REQ_INSERT = 1'b0,
    REQ_LOOKUP = 1'b1
  } req_id_e;

  // Arbiter ownership mode
  typedef enum logic [0:0] {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Tag travelling alongside a request through the hash latency
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } hash_tag_t;

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_hash_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fib_hash_tag_pipe                                           |
// | Brief  : Shift register of DEPTH stages carrying {valid,id} so that  |
// |          each hash result can be routed back to its requester.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fib_hash_tag_pipe
  import fib_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  hash_tag_t tag_in,
  output hash_tag_t tag_out
);

  hash_tag_t r_stage [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      // First stage captures the tag of the request granted this cycle
      always_ff @(posedge clk) begin
        if (!rst) r_stage[i] <= '0;
        else      r_stage[i] <= tag_in;
      end
    end else begin : g_body
      // Later stages simply advance the tag one cycle
      always_ff @(posedge clk) begin
        if (!rst) r_stage[i] <= '0;
        else      r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign tag_out = r_stage[DEPTH-1];

endmodule : fib_hash_tag_pipe
`default_nettype wire

// File: rtl/fib_hash_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fib_hash_arbiter                                            |
// | Brief  : Shares one FIB hash unit between the insert path (req0) and |
// |          the LPM lookup path (req1). Round-robin when open; a lookup |
// |          lock gives req1 priority with one forced req0 grant every   |
// |          MAX_LOCK lookup grants. Responses return in grant order.    |
// | Option : FIB_HASH_ARB_STATS_EN adds saturating grant/force counters. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fib_hash_arbiter
  import fib_pkg::*;
#(
  parameter int HASH_LAT = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic [PREFIX_W-1:0] prefix0,
  input  logic [LEN_W-1:0]    len0,
  output logic                gnt0,
  output logic                resp0_valid,
  input  logic                req1,
  input  logic [PREFIX_W-1:0] prefix1,
  input  logic [LEN_W-1:0]    len1,
  input  logic                lock1,
  output logic                gnt1,
  output logic                resp1_valid,
  output logic [HASH_W-1:0]   resp_hash,
  output logic [PREFIX_W-1:0] hash_prefix,
  output logic [LEN_W-1:0]    hash_len,
  input  logic [HASH_W-1:0]   hash_value,
  output logic                locked
`ifdef FIB_HASH_ARB_STATS_EN
  ,
  output logic [15:0]         gnt0_cnt,
  output logic [15:0]         gnt1_cnt,
  output logic [15:0]         force_cnt
`endif
);

  localparam int             CNT_W       = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] c_max_lock = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  arb_state_e       r_state,    w_state_nxt;
  req_id_e          r_rr_last,  w_rr_nxt;
  logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic             w_gnt0, w_gnt1, w_force;
  hash_tag_t        w_tag_in, w_tag_out;

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ARB_OPEN;
      r_rr_last  <= REQ_LOOKUP;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_last  <= w_rr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Grant decision and next-state; grants are suppressed while in reset
  always_comb begin
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
    w_force        = 1'b0;
    w_state_nxt    = r_state;
    w_rr_nxt       = r_rr_last;
    w_lock_cnt_nxt = r_lock_cnt;
    if (rst) begin
      case (r_state)
        ARB_OPEN: begin
          if (req0 && req1) begin
            if (r_rr_last == REQ_LOOKUP) w_gnt0 = 1'b1;
            else                         w_gnt1 = 1'b1;
          end else if (req0) begin
            w_gnt0 = 1'b1;
          end else if (req1) begin
            w_gnt1 = 1'b1;
          end
          if (w_gnt0) w_rr_nxt = REQ_INSERT;
          if (w_gnt1) begin
            w_rr_nxt = REQ_LOOKUP;
            // The grant that takes the lock counts toward the lock budget
            if (lock1) begin
              w_state_nxt    = ARB_LOCKED;
              w_lock_cnt_nxt = c_one;
            end
          end
        end
        ARB_LOCKED: begin
          if (req0 && (r_lock_cnt == c_max_lock)) begin
            w_gnt0         = 1'b1;
            w_force        = 1'b1;
            w_lock_cnt_nxt = '0;
          end else if (req1) begin
            w_gnt1 = 1'b1;
            // Hold at the budget so a waiting req0 still sees the limit
            if (r_lock_cnt != c_max_lock) w_lock_cnt_nxt = r_lock_cnt + c_one;
          end else if (req0) begin
            w_gnt0 = 1'b1;
          end
          if (!lock1) begin
            w_state_nxt    = ARB_OPEN;
            w_lock_cnt_nxt = '0;
            w_rr_nxt       = REQ_LOOKUP;
          end
        end
        default: w_state_nxt = ARB_OPEN;
      endcase
    end
  end

  assign gnt0   = w_gnt0;
  assign gnt1   = w_gnt1;
  assign locked = (r_state == ARB_LOCKED);

  // Present the granted key to the hash unit and hold it until the next grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      hash_prefix <= '0;
      hash_len    <= '0;
    end else if (w_gnt1) begin
      hash_prefix <= prefix1;
      hash_len    <= len1;
    end else if (w_gnt0) begin
      hash_prefix <= prefix0;
      hash_len    <= len0;
    end
  end

  assign w_tag_in.valid = w_gnt0 | w_gnt1;
  assign w_tag_in.id    = w_gnt1 ? REQ_LOOKUP : REQ_INSERT;

  // One extra stage covers the cycle spent registering the hash inputs
  fib_hash_tag_pipe #(
    .DEPTH (HASH_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (w_tag_in),
    .tag_out (w_tag_out)
  );

  // Capture the hash result and steer the ready pulse to its owner
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_hash   <= '0;
    end else begin
      resp0_valid <= w_tag_out.valid && (w_tag_out.id == REQ_INSERT);
      resp1_valid <= w_tag_out.valid && (w_tag_out.id == REQ_LOOKUP);
      if (w_tag_out.valid) resp_hash <= hash_value;
    end
  end

`ifdef FIB_HASH_ARB_STATS_EN
  // Saturating grant statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt0_cnt  <= '0;
      gnt1_cnt  <= '0;
      force_cnt <= '0;
    end else begin
      if (w_gnt0  && (gnt0_cnt  != 16'hFFFF)) gnt0_cnt  <= gnt0_cnt  + 16'd1;
      if (w_gnt1  && (gnt1_cnt  != 16'hFFFF)) gnt1_cnt  <= gnt1_cnt  + 16'd1;
      if (w_force && (force_cnt != 16'hFFFF)) force_cnt <= force_cnt + 16'd1;
    end
  end
`endif

endmodule : fib_hash_arbiter
`default_nettype wire

// File: tb/tb_fib_hash_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_fib_hash_arbiter                                         |
// | Brief  : Self-checking bench for fib_hash_arbiter: directed scenarios|
// |          followed by random traffic against a grant/response model.  |
// |          Stats checks are active when FIB_HASH_ARB_STATS_EN is set.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_fib_hash_arbiter;

  localparam int HASH_LAT = 1;
  localparam int MAX_LOCK = 4;

  logic        clk;
  logic        rst;
  logic        req0, req1, lock1;
  logic [63:0] prefix0, prefix1;
  logic [5:0]  len0, len1;
  logic        gnt0, gnt1, resp0_valid, resp1_valid, locked;
  logic [9:0]  resp_hash, hash_value;
  logic [63:0] hash_prefix;
  logic [5:0]  hash_len;
`ifdef FIB_HASH_ARB_STATS_EN
  logic [15:0] gnt0_cnt, gnt1_cnt, force_cnt;
`endif

  fib_hash_arbiter #(
    .HASH_LAT (HASH_LAT),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .prefix0     (prefix0),
    .len0        (len0),
    .gnt0        (gnt0),
    .resp0_valid (resp0_valid),
    .req1        (req1),
    .prefix1     (prefix1),
    .len1        (len1),
    .lock1       (lock1),
    .gnt1        (gnt1),
    .resp1_valid (resp1_valid),
    .resp_hash   (resp_hash),
    .hash_prefix (hash_prefix),
    .hash_len    (hash_len),
    .hash_value  (hash_value),
    .locked      (locked)
`ifdef FIB_HASH_ARB_STATS_EN
    ,
    .gnt0_cnt    (gnt0_cnt),
    .gnt1_cnt    (gnt1_cnt),
    .force_cnt   (force_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in hash function for the external hash unit
  function automatic logic [9:0] fhash(input logic [63:0] p, input logic [5:0] l);
    logic [69:0] x;
    logic [9:0]  r;
    x = {l, p};
    r = 10'h2A5;
    for (int i = 0; i < 7; i++) r = {r[8:0], r[9]} ^ x[i*10 +: 10];
    return r;
  endfunction

  // External hash unit with HASH_LAT cycles of latency
  logic [9:0] hpipe [HASH_LAT];
  initial for (int i = 0; i < HASH_LAT; i++) hpipe[i] = '0;
  always @(posedge clk) begin
    hpipe[0] <= fhash(hash_prefix, hash_len);
    for (int i = 1; i < HASH_LAT; i++) hpipe[i] <= hpipe[i-1];
  end
  assign hash_value = hpipe[HASH_LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: arbitration rules plus an ordered list of expected responses
  typedef struct {
    int         due;
    bit         id;
    logic [9:0] h;
  } exp_t;
  exp_t        exp_q[$];
  bit          m_locked = 1'b0;
  bit          m_rr     = 1'b1;   // last winner; 1 means req0 wins the next tie
  int          m_cnt    = 0;
  logic [63:0] m_prefix = '0;
  logic [5:0]  m_len    = '0;
  int          m_g0cnt = 0, m_g1cnt = 0, m_fcnt = 0;

  function automatic void model_grant(input logic r0, input logic r1, input logic rs,
                                      output logic g0, output logic g1, output logic frc);
    g0 = 1'b0; g1 = 1'b0; frc = 1'b0;
    if (rs) begin
      if (m_locked) begin
        if (r0 && m_cnt == MAX_LOCK) begin g0 = 1'b1; frc = 1'b1; end
        else if (r1) g1 = 1'b1;
        else if (r0) g0 = 1'b1;
      end else begin
        if (r0 && r1) begin
          if (m_rr) g0 = 1'b1; else g1 = 1'b1;
        end else begin
          g0 = r0;
          g1 = r1;
        end
      end
    end
  endfunction

  function automatic void model_update(input logic g0, input logic g1, input logic frc);
    if (!rst) begin
      m_locked = 1'b0; m_rr = 1'b1; m_cnt = 0;
      m_prefix = '0; m_len = '0;
      exp_q.delete();
      m_g0cnt = 0; m_g1cnt = 0; m_fcnt = 0;
    end else begin
      if (g0 || g1) begin
        m_prefix = g1 ? prefix1 : prefix0;
        m_len    = g1 ? len1 : len0;
        exp_q.push_back('{due: cyc + HASH_LAT + 2, id: g1, h: fhash(m_prefix, m_len)});
      end
      if (g0  && m_g0cnt < 65535) m_g0cnt++;
      if (g1  && m_g1cnt < 65535) m_g1cnt++;
      if (frc && m_fcnt  < 65535) m_fcnt++;
      if (m_locked) begin
        if (!lock1) begin m_locked = 1'b0; m_cnt = 0; m_rr = 1'b1; end
        else if (frc) m_cnt = 0;
        else if (g1 && m_cnt < MAX_LOCK) m_cnt++;
      end else begin
        if (g0) m_rr = 1'b0;
        if (g1) begin
          m_rr = 1'b1;
          if (lock1) begin m_locked = 1'b1; m_cnt = 1; end
        end
      end
    end
  endfunction

  // Values sampled mid-cycle by the last tick, for directed checks
  logic        s_gnt0, s_gnt1, s_locked, s_r0v, s_r1v;
  logic [9:0]  s_rhash;
  logic [63:0] s_hprefix;
  logic [5:0]  s_hlen;

  // One clock cycle: compare outputs at negedge, advance model at posedge
  task automatic tick();
    logic g0, g1, frc, ev0, ev1;
    logic [9:0] eh;
    @(negedge clk);
    model_grant(req0, req1, rst, g0, g1, frc);
    s_gnt0 = gnt0; s_gnt1 = gnt1; s_locked = locked;
    s_r0v = resp0_valid; s_r1v = resp1_valid; s_rhash = resp_hash;
    s_hprefix = hash_prefix; s_hlen = hash_len;
    check("gnt0", gnt0, g0);
    check("gnt1", gnt1, g1);
    check("locked", locked, m_locked);
    ev0 = 1'b0; ev1 = 1'b0; eh = '0;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      ev0 = !exp_q[0].id;
      ev1 = exp_q[0].id;
      eh  = exp_q[0].h;
      void'(exp_q.pop_front());
    end
    check("resp0_valid", resp0_valid, ev0);
    check("resp1_valid", resp1_valid, ev1);
    if (ev0 || ev1) check("resp_hash", resp_hash, eh);
    check("hash_prefix", hash_prefix, m_prefix);
    check("hash_len", hash_len, m_len);
    @(posedge clk);
    model_update(g0, g1, frc);
    cyc++;
    #1;
  endtask

  initial begin
    logic [0:9] lock_pat;
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; lock1 = 1'b0;
    prefix0 = 64'h1111; prefix1 = 64'h2222; len0 = 6'd1; len1 = 6'd2;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with both requests high: nothing granted, outputs zero
    repeat (2) tick();
    check("rst_no_gnt", {s_gnt0, s_gnt1}, 2'b00);
    check("rst_resp_hash", s_rhash, 10'd0);

    // First tie after release goes to req0
    rst = 1'b1;
    tick();
    check("first_tie_gnt0", s_gnt0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();

    // Single insert request and its response three cycles later
    req0 = 1'b1; prefix0 = 64'h0123_4567_89AB_CDEF; len0 = 6'd20;
    tick();
    check("single_gnt0", s_gnt0, 1'b1);
    req0 = 1'b0;
    tick();
    check("single_hprefix", s_hprefix, 64'h0123_4567_89AB_CDEF);
    check("single_hlen", s_hlen, 6'd20);
    tick();
    tick();
    check("single_resp0", s_r0v, 1'b1);
    check("single_hash", s_rhash, fhash(64'h0123_4567_89AB_CDEF, 6'd20));

    // A lookup-only grant so the next tie belongs to req0
    req1 = 1'b1; prefix1 = 64'hFEDC_BA98_7654_3210; len1 = 6'd48;
    tick();
    check("lookup_gnt1", s_gnt1, 1'b1);
    req1 = 1'b0;
    repeat (4) tick();

    // Round robin with both held
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      prefix0 = {$urandom, $urandom}; prefix1 = {$urandom, $urandom};
      tick();
      check("rr_gnt0", s_gnt0, (i % 2) == 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();

    // Lock: gnt1 x4, forced gnt0, gnt1 x4, forced gnt0
    lock_pat = 10'b1111011110;
    req1 = 1'b1; lock1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      req0 = 1'b1;
      check("lock_gnt1", s_gnt1, lock_pat[i]);
      if (i > 0) check("lock_locked", s_locked, 1'b1);
    end
`ifdef FIB_HASH_ARB_STATS_EN
    check("force_cnt_lock", force_cnt, 16'd2);
`endif
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    tick();
    check("unlock_still_locked", s_locked, 1'b1);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("unlock_open", s_locked, 1'b0);
    check("unlock_tie_gnt0", s_gnt0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();

    // Reset while a lookup is in flight drops its response
    req1 = 1'b1;
    tick();
    req1 = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midflight_no_resp1", s_r1v, 1'b0);
    end

    // Random traffic including occasional resets
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(63) != 0);
      req0    = 1'($urandom_range(1));
      req1    = 1'($urandom_range(1));
      lock1   = ($urandom_range(3) != 0);
      prefix0 = {$urandom, $urandom};
      prefix1 = {$urandom, $urandom};
      len0    = 6'($urandom_range(63));
      len1    = 6'($urandom_range(63));
      tick();
    end
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    repeat (4) tick();

`ifdef FIB_HASH_ARB_STATS_EN
    check("rand_gnt0_cnt", gnt0_cnt, 16'(m_g0cnt));
    check("rand_gnt1_cnt", gnt1_cnt, 16'(m_g1cnt));
    check("rand_force_cnt", force_cnt, 16'(m_fcnt));
    req0 = 1'b1;
    repeat (70000) tick();
    req0 = 1'b0;
    tick();
    check("sat_gnt0_cnt", gnt0_cnt, 16'hFFFF);
    check("sat_gnt1_cnt", gnt1_cnt, 16'(m_g1cnt));
    check("sat_force_cnt", force_cnt, 16'(m_fcnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fib_hash_arbiter
`default_nettype wire

// File: doc/fib_hash_arbiter.md
Name: fib_hash_arbiter

Overview:
- Shares the single FIB hash unit between the two FIB requesters: req0 = insert path (save prefix valid bit), req1 = lookup path (longest-prefix-match loop).
- Drives the hash unit inputs, tracks in-flight requests and returns each hash to its owner.
- Round-robin arbitration, with a bounded lock so an LPM walk of up to 64 lengths can run back-to-back.
- Sits between the FIB control FSMs and the hash instance; it replaces direct multi-driver access to the hash inputs.

Parameters:
- HASH_LAT, 1, cycles from hash inputs valid to hash_value valid (>=1).
- MAX_LOCK, 16, maximum consecutive req1 grants under lock before one forced req0 grant.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- req0  in  1  insert-path request; held until gnt0
- prefix0  in  64  insert prefix; stable while req0 high
- len0  in  6  insert prefix length
- gnt0  out  1  one-cycle grant to req0
- resp0_valid  out  1  one-cycle hash-ready pulse for req0
- req1  in  1  lookup-path request
- prefix1  in  64  lookup prefix
- len1  in  6  lookup length
- lock1  in  1  lookup requests exclusive ownership across successive requests
- gnt1  out  1  one-cycle grant to req1
- resp1_valid  out  1  one-cycle hash-ready pulse for req1
- resp_hash  out  10  returned hash; valid with resp0_valid or resp1_valid
- hash_prefix  out  64  to hash unit
- hash_len  out  6  to hash unit
- hash_value  in  10  from hash unit
- locked  out  1  high while the arbiter is in LOCKED state

Behaviour:
- Reset (rst=0 at posedge):
  - All outputs are 0.
  - rr_last=1, so req0 wins the first tie.
  - Tag pipeline cleared; in-flight requests are dropped and get no response.
  - lock_cnt=0; state=OPEN.
- Grants are combinational in cycle T from registered state and current req/lock. At most one gnt per cycle; gnt is only asserted with its req high.
- Granted prefix/len are registered into hash_prefix/hash_len at the end of T and held until the next grant.
- A tag {valid, id} enters a shift pipeline of depth HASH_LAT+1.
- resp_hash is hash_value registered; respX_valid pulses in cycle T+HASH_LAT+2 (T+3 at default).
- Fully pipelined: one grant per cycle, so a requester holding req high is granted every cycle it wins.
- FSM states:
  - OPEN:
    - Only one req high: grant it.
    - Both high: grant the non-rr_last requester; update rr_last.
    - Transition to LOCKED when gnt1 && lock1.
  - LOCKED:
    - req1 has absolute priority; each gnt1 increments lock_cnt.
    - req0 is granted only when req1 is low.
    - If lock_cnt==MAX_LOCK and req0 is high: force gnt0 (gnt1 low that cycle), clear lock_cnt, stay LOCKED.
    - lock1 low: return to OPEN next cycle with lock_cnt=0 and rr_last=1.
- Simultaneous lock1 rise with req0-only: no effect until gnt1 occurs.
- locked=1 exactly in LOCKED.
- Responses preserve grant order; requesters need no reorder logic.

Optional Feature:
- FIB_HASH_ARB_STATS_EN:
  - Defined: adds outputs gnt0_cnt[15:0], gnt1_cnt[15:0] and force_cnt[15:0] (forced req0 grants in LOCKED). All are saturating at 16'hFFFF and cleared on reset.
  - Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fib_pkg:
  - PREFIX_W=64, LEN_W=6, HASH_W=10
  - requester id enum REQ_INSERT=0, REQ_LOOKUP=1
  - arbiter state enum ARB_OPEN, ARB_LOCKED
- Natural sub-module: fib_hash_tag_pipe, a parameterised tag shift register of depth HASH_LAT+1 carrying {valid,id}.

Test Plan:
- Reset check: rst=0 for 2 cycles with req0=req1=1 -> no gnt, all outputs 0; after release, first tie grants req0.
- Single request: req0=1, prefix0=64'h0123_4567_89AB_CDEF, len0=6'd20 at T -> gnt0 at T; hash_prefix/hash_len match at T+1; resp0_valid with resp_hash=model hash at T+3 (HASH_LAT=1).
- Round-robin: req0=req1=1 held for 6 cycles, lock1=0 -> grants alternate 0,1,0,1,0,1; responses arrive in the same order 3 cycles later.
- Lock with forced grant: MAX_LOCK=4, lock1=1, req1 and req0 held -> gnt1 x4, gnt0 x1, gnt1 x4; locked=1 throughout; lock1 low -> OPEN, next tie grants req0.
- Reset mid-flight: grant req1 at T, rst=0 at T+1 -> no resp1_valid at T+3; all state reinitialised.
- With FIB_HASH_ARB_STATS_EN: 70000 req0-only grants -> gnt0_cnt saturates at 16'hFFFF; force_cnt counts each forced grant from the lock scenario.
